fifo_ptr_ctrl: RTL
==================

// Module: fifo_ptr_ctrl
// PURPOSE
//  Pointer/flag controller for the 8-entry x 8-bit FIFO storage array.
//  - Tracks write and read pointers; issues the write address/enable that feeds decoder3_8 (one-hot row select) and the read address for the output mux.
//  - Produces full/empty/almost_full flags and an occupancy count.
//  - Sits directly upstream of decoder3_8, between the FIFO user ports and the register array.
// PARAMETERS
//  ADDR_W    3  address width; depth = 2**ADDR_W (3 -> 8 entries, matches decoder3_8)
//  AFULL_TH  6  almost_full asserts when count >= AFULL_TH (1..2**ADDR_W)
// PORTS
//  clk          in   1         rising-edge clock, sole clock domain
//  rst          in   1         synchronous reset, active-high
//  wr_req       in   1         write request from producer
//  rd_req       in   1         read request from consumer
//  wr_addr      out  ADDR_W    write row index -> decoder3_8 data_in
//  wr_sel       out  1         write strobe -> decoder3_8 enable (=accepted write)
//  rd_addr      out  ADDR_W    read row index -> output mux select
//  rd_sel       out  1         accepted read this cycle
//  full         out  1         2**ADDR_W entries held
//  empty        out  1         0 entries held
//  almost_full  out  1         count >= AFULL_TH
//  count        out  ADDR_W+1  occupancy, 0..2**ADDR_W
//  overflow     out  1         sticky: write attempted while full (FIFO_PTR_ERR_EN only)
//  underflow    out  1         sticky: read attempted while empty (FIFO_PTR_ERR_EN only)
// BEHAVIOUR
//  - Internal wr_ptr, rd_ptr: ADDR_W+1 bits (MSB = wrap bit); the low ADDR_W bits are the row index.
//  - Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=underflow=0.
//    Reset mid-operation discards all contents; takes priority over any wr_req/rd_req that cycle.
//  - Accept rules (combinational, same cycle): wr_sel = wr_req & ~full; rd_sel = rd_req & ~empty.
//    - A write while full is rejected even if a read is accepted in the same cycle.
//    - A read while empty is rejected even if a write is accepted in the same cycle (no fall-through).
//  - wr_addr = wr_ptr[ADDR_W-1:0], rd_addr = rd_ptr[ADDR_W-1:0], both combinational from registered pointers.
//    The array captures data at the edge ending the wr_sel cycle.
//  - On the clk edge: wr_ptr += wr_sel; rd_ptr += rd_sel (mod 2**(ADDR_W+1), natural wrap).
//  - count: +1 on write only, -1 on read only, unchanged on both or neither. Registered.
//  - empty = (wr_ptr == rd_ptr); full = (MSBs differ & low bits equal).
//    Both are registered or derived from registered state: no combinational path from req to flags.
//  - almost_full derived from registered count; flags update one cycle after the accepted operation.
//  - Invariant: count == wr_ptr - rd_ptr (mod 2**(ADDR_W+1)); full/empty never both 1.
// CONFIGURATION
//  FIFO_PTR_ERR_EN defined:
//   - overflow sets on wr_req & full; underflow sets on rd_req & empty.
//   - Both flags are sticky until rst.
//  FIFO_PTR_ERR_EN undefined:
//   - overflow/underflow ports remain and are tied 0.
//   - No error registers are built.
// TESTING
//  1 rst held 2 cycles, then released -> empty=1, full=0, count=0, wr_addr=rd_addr=0, wr_sel=rd_sel=0.
//  2 8 consecutive wr_req -> wr_addr 0..7 with wr_sel=1 each cycle; after the 8th edge full=1, count=8; almost_full=1 from count=6.
//  3 From full, wr_req+rd_req together -> wr_sel=0, rd_sel=1, rd_addr=0; next cycle count=7, full=0.
//  4 Wrap: write 8, read 8, write 3 -> wr_addr 0,1,2 again, wr_ptr MSB=1; empty=0, count=3.
//  5 Count=4, simultaneous wr_req+rd_req for 10 cycles -> count stays 4, both pointers advance by 10 (mod 16).
//  6 With FIFO_PTR_ERR_EN: rd_req while empty -> underflow=1, stays 1 after later writes; rst clears it. Without the macro -> underflow stays 0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for the 8-entry FIFO register array.
// Optional sticky overflow/underflow registers are built when FIFO_PTR_ERR_EN is defined.
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count_q;

  // Flags come only from registered pointers/count, so requests never reach them combinationally.
  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    almost_full = (count_q >= PTR_W'(AFULL_TH));
    wr_sel      = wr_req & ~full;
    rd_sel      = rd_req & ~empty;
    wr_addr     = wr_ptr[ADDR_W-1:0];
    rd_addr     = rd_ptr[ADDR_W-1:0];
    count       = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_sel);
      rd_ptr <= rd_ptr + PTR_W'(rd_sel);
      unique case ({wr_sel, rd_sel})
        2'b10:   count_q <= count_q + PTR_W'(1);
        2'b01:   count_q <= count_q - PTR_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FIFO_PTR_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error capture; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_req && full)
        overflow_q <= 1'b1;
      if (rd_req && empty)
        underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
